// File: rtl/notas_pkg.sv
// notas_pkg: shared constants and types for the tone generator slice.
//   NOTA_W        default width of the note frequency (Hz)
//   CNT_W         default width of dividend, quotient and period counter
//   NOTA_SILENCIO note code meaning "no tone"
//   estado_t      control FSM states (IDLE -> DIV -> LOAD -> IDLE)
package notas_pkg;

    localparam int unsigned NOTA_W        = 16;
    localparam int unsigned CNT_W         = 32;
    localparam int unsigned NOTA_SILENCIO = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_LOAD
    } estado_t;

endpackage

// File: rtl/generador_tono_if.sv
// generador_tono_if: note request / tone status bundle.
//   nota      requested frequency in Hz (0 = silence)   master -> slave
//   en        play enable                               master -> slave
//   tono_out  square-wave output                        slave -> master
//   busy      division in progress                      slave -> master
//   silencio  loaded note is silence                    slave -> master
interface generador_tono_if #(
    parameter int unsigned NOTA_W = notas_pkg::NOTA_W
);

    logic [NOTA_W-1:0] nota;
    logic              en;
    logic              tono_out;
    logic              busy;
    logic              silencio;

    modport master (
        output nota,
        output en,
        input  tono_out,
        input  busy,
        input  silencio
    );

    modport slave (
        input  nota,
        input  en,
        output tono_out,
        output busy,
        output silencio
    );

endinterface

// File: rtl/divisor_restaurador.sv
// divisor_restaurador: unsigned restoring divider, one quotient bit per clock.
//   clk, rst     clock, asynchronous active-high reset
//   start_i      load operands and begin (ignored while a division runs only
//                by the caller's choice; a new start restarts the divider)
//   dividend_i   DVD_W-bit dividend
//   divisor_i    DVS_W-bit divisor (must be non-zero)
//   quotient_o   DVD_W-bit quotient, valid once the final step has completed
//   done_o       high during the clock whose edge performs the final step
module divisor_restaurador #(
    parameter int unsigned DVD_W = notas_pkg::CNT_W,
    parameter int unsigned DVS_W = notas_pkg::NOTA_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVD_W-1:0] quotient_o,
    output logic             done_o
);

    localparam int unsigned PW = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q;
    logic [DVD_W-1:0] dvd_q;
    logic [DVD_W-1:0] quo_q;
    logic [PW-1:0]    pasos_q;
    logic [DVS_W:0]   parcial;
    logic             qbit;

    // The remainder is always below the divisor, so DVS_W bits hold it and
    // the shifted partial remainder needs only one extra bit.
    always_comb begin
        parcial = {rem_q, dvd_q[DVD_W-1]};
        qbit    = (parcial >= {1'b0, dvs_q});
        rem_d   = parcial[DVS_W-1:0];
        if (qbit) begin
            rem_d = DVS_W'(parcial - {1'b0, dvs_q});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            pasos_q <= '0;
        end else if (start_i) begin
            rem_q   <= '0;
            dvs_q   <= divisor_i;
            dvd_q   <= dividend_i;
            quo_q   <= '0;
            pasos_q <= PW'(DVD_W);
        end else if (pasos_q != '0) begin
            rem_q   <= rem_d;
            dvd_q   <= {dvd_q[DVD_W-2:0], 1'b0};
            quo_q   <= {quo_q[DVD_W-2:0], qbit};
            pasos_q <= pasos_q - 1'b1;
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = (pasos_q == PW'(1));

endmodule

// File: rtl/generador_tono.sv
// generador_tono: 50%-duty square wave from a note frequency in Hz.
//   Half-period in clocks = max(floor(CLK_HZ / (2*nota)), 1), recomputed by a
//   sequential divider whenever nota changes; nota == 0 means silence.
//   clk, rst          clock, asynchronous active-high reset
//   tono_if (slave)   nota, en in; tono_out, busy, silencio out
// Build option: define TONO_SYNC_EN to let a new half-period take effect only
// at the next toggle; otherwise the counter is reloaded as soon as it is known.
module generador_tono #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned NOTA_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    generador_tono_if.slave tono_if
);

    import notas_pkg::*;

    localparam int unsigned DVS_W = NOTA_W + 1;

`ifdef TONO_SYNC_EN
    localparam bit RECARGA_EN_LOAD = 1'b0;
`else
    localparam bit RECARGA_EN_LOAD = 1'b1;
`endif

    estado_t           estado_q;
    logic [NOTA_W-1:0] nota_reg_q;
    logic [CNT_W-1:0]  semi_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_act;
    logic [CNT_W-1:0]  quotient;
    logic [CNT_W-1:0]  semi_nuevo;
    logic [DVS_W-1:0]  divisor;
    logic              busy_q;
    logic              silencio_q;
    logic              tono_q, tono_d;
    logic              activo_q;
    logic              activo;
    logic              div_start;
    logic              div_done;
    logic              nota_cero;

    assign nota_cero  = (tono_if.nota == NOTA_W'(NOTA_SILENCIO));
    assign div_start  = (estado_q == ST_IDLE) && (tono_if.nota != nota_reg_q) && !nota_cero;
    assign divisor    = {tono_if.nota, 1'b0};
    assign semi_nuevo = (quotient == '0) ? CNT_W'(1) : quotient;

    divisor_restaurador #(
        .DVD_W (CNT_W),
        .DVS_W (DVS_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (CNT_W'(CLK_HZ)),
        .divisor_i  (divisor),
        .quotient_o (quotient),
        .done_o     (div_done)
    );

    // Control FSM. A note change during DIV is not aborted: the running
    // division loads, and IDLE then notices the mismatch and restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= ST_IDLE;
            nota_reg_q <= '0;
            semi_q     <= '0;
            busy_q     <= 1'b0;
            silencio_q <= 1'b1;
        end else begin
            case (estado_q)
                ST_IDLE: begin
                    if (tono_if.nota != nota_reg_q) begin
                        nota_reg_q <= tono_if.nota;
                        if (nota_cero) begin
                            estado_q <= ST_LOAD;
                        end else begin
                            busy_q   <= 1'b1;
                            estado_q <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        busy_q   <= 1'b0;
                        estado_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (nota_reg_q == NOTA_W'(NOTA_SILENCIO)) begin
                        semi_q     <= '0;
                        silencio_q <= 1'b1;
                    end else begin
                        semi_q     <= semi_nuevo;
                        silencio_q <= 1'b0;
                    end
                    estado_q <= ST_IDLE;
                end
                default: estado_q <= ST_IDLE;
            endcase
        end
    end

    assign activo = tono_if.en && !silencio_q;

    // While idle the counter rests at 0; on the first active clock it behaves
    // as if a toggle had just happened, so the first rising edge comes after
    // exactly semi clocks.
    always_comb begin
        cnt_d   = cnt_q;
        tono_d  = tono_q;
        cnt_act = activo_q ? cnt_q : semi_q - 1'b1;
        if (!activo) begin
            cnt_d  = '0;
            tono_d = 1'b0;
        end else begin
            if (cnt_act == '0) begin
                tono_d = ~tono_q;
                cnt_d  = semi_q - 1'b1;
            end else begin
                cnt_d = cnt_act - 1'b1;
            end
            // Immediate reload keeps the output level; the current
            // half-cycle is cut short or stretched to the new length.
            if (RECARGA_EN_LOAD && (estado_q == ST_LOAD) &&
                (nota_reg_q != NOTA_W'(NOTA_SILENCIO))) begin
                tono_d = tono_q;
                cnt_d  = semi_nuevo - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            tono_q   <= 1'b0;
            activo_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tono_q   <= tono_d;
            activo_q <= activo;
        end
    end

    assign tono_if.tono_out = tono_q;
    assign tono_if.busy     = busy_q;
    assign tono_if.silencio = silencio_q;

endmodule

// File: tb/tb_generador_tono.sv
// tb_generador_tono: directed bench for generador_tono with a queue of
// expected half-periods (pushed when a note is driven, popped when measured).
module tb_generador_tono;

    localparam int unsigned CLK_TB    = 1_000_000;
    localparam int unsigned CLK_CLAMP = 100_000;
    localparam int unsigned LAT       = 34;
    localparam int          LIMITE    = 10000;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    generador_tono_if #(.NOTA_W(16)) ifc ();
    generador_tono_if #(.NOTA_W(16)) ifc2 ();

    generador_tono #(
        .CLK_HZ (CLK_TB),
        .NOTA_W (16),
        .CNT_W  (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tono_if (ifc)
    );

    generador_tono #(
        .CLK_HZ (CLK_CLAMP),
        .NOTA_W (16),
        .CNT_W  (32)
    ) dut_clamp (
        .clk     (clk),
        .rst     (rst),
        .tono_if (ifc2)
    );

    always #5 clk = ~clk;

    function automatic int semi_model(input int unsigned hz, input int unsigned n);
        int unsigned q;
        if (n == 0) return 0;
        q = hz / (2 * n);
        return (q == 0) ? 1 : int'(q);
    endfunction

    function automatic logic tono(input bit sel);
        return sel ? ifc2.tono_out : ifc.tono_out;
    endfunction

    function automatic logic ocupado(input bit sel);
        return sel ? ifc2.busy : ifc.busy;
    endfunction

    task automatic check(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Negedges until tono_out changes level; -1 if it never does.
    task automatic wait_toggle(input bit sel, output int n);
        logic prev;
        bit   hecho;
        prev  = tono(sel);
        n     = 0;
        hecho = 1'b0;
        while (!hecho && n < LIMITE) begin
            @(negedge clk);
            n++;
            if (tono(sel) !== prev) hecho = 1'b1;
        end
        if (!hecho) n = -1;
    endtask

    // Negedges until tono_out goes high, counting busy samples on the way.
    task automatic arranque(input bit sel, output int n, output int nb);
        bit hecho;
        n     = 0;
        nb    = 0;
        hecho = 1'b0;
        while (!hecho && n < LIMITE) begin
            @(negedge clk);
            n++;
            if (ocupado(sel) === 1'b1) nb++;
            if (tono(sel) === 1'b1) hecho = 1'b1;
        end
        if (!hecho) n = -1;
    endtask

    // Called right after a rising edge was observed: one high + one low phase.
    task automatic medir_ciclo(input bit sel, input string tag, input int h);
        int nh, nl;
        wait_toggle(sel, nh);
        check({tag, "_alto"}, nh, h);
        wait_toggle(sel, nl);
        check({tag, "_bajo"}, nl, h);
        check({tag, "_periodo"}, nh + nl, 2 * h);
    endtask

    initial begin
        int n, nb, h, nh, semi_prev;

        rst       = 1'b1;
        ifc.nota  = '0;
        ifc.en    = 1'b0;
        ifc2.nota = '0;
        ifc2.en   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tono", ifc.tono_out, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_silencio", ifc.silencio, 1);
        rst = 1'b0;

        // Reset in the middle of a division, then restart.
        ifc.nota = 16'd261;
        ifc.en   = 1'b1;
        repeat (10) @(negedge clk);
        check("div_en_curso_busy", ifc.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_div_tono", ifc.tono_out, 0);
        check("rst_div_busy", ifc.busy, 0);
        check("rst_div_silencio", ifc.silencio, 1);
        rst = 1'b0;
        exp_q.push_back(semi_model(CLK_TB, 261));

        // 261 Hz from reset.
        arranque(0, n, nb);
        h = exp_q.pop_front();
        check("t261_busy", nb, 32);
        check("t261_arranque", n, int'(LAT) + h);
        check("t261_silencio", ifc.silencio, 0);
        medir_ciclo(0, "t261", h);
        semi_prev = h;

        // 261 -> 440 right after a rising edge.
        ifc.nota = 16'd440;
        exp_q.push_back(semi_model(CLK_TB, 440));
        h = exp_q.pop_front();
        wait_toggle(0, nh);
`ifdef TONO_SYNC_EN
        check("t440_fase_cambio", nh, semi_prev);
`else
        check("t440_fase_cambio", nh, int'(LAT) + h);
`endif
        wait_toggle(0, nh);
        check("t440_primer_bajo", nh, h);
        medir_ciclo(0, "t440", h);

        // Silence, then 392 Hz.
        ifc.nota = 16'd0;
        repeat (2) @(negedge clk);
        check("t0_silencio", ifc.silencio, 1);
        nh = 0;
        repeat (50) begin
            @(negedge clk);
            if (ifc.tono_out !== 1'b0) nh++;
        end
        check("t0_tono_bajo", nh, 0);
        ifc.nota = 16'd392;
        exp_q.push_back(semi_model(CLK_TB, 392));
        arranque(0, n, nb);
        h = exp_q.pop_front();
        check("t392_busy", nb, 32);
        check("t392_arranque", n, int'(LAT) + h);
        medir_ciclo(0, "t392", h);

        // High notes, changed while disabled.
        ifc.en = 1'b0;
        @(negedge clk);
        check("en0_tono", ifc.tono_out, 0);
        ifc.nota = 16'd60000;
        exp_q.push_back(semi_model(CLK_TB, 60000));
        repeat (40) @(negedge clk);
        ifc.en = 1'b1;
        arranque(0, n, nb);
        h = exp_q.pop_front();
        check("t60000_arranque", n, h);
        medir_ciclo(0, "t60000", h);

        ifc.en = 1'b0;
        ifc.nota = 16'd65535;
        exp_q.push_back(semi_model(CLK_TB, 65535));
        repeat (40) @(negedge clk);
        ifc.en = 1'b1;
        arranque(0, n, nb);
        h = exp_q.pop_front();
        check("t65535_arranque", n, h);
        medir_ciclo(0, "t65535", h);

        // Quotient 0 clamps to a half-period of one clock.
        ifc2.nota = 16'd60000;
        ifc2.en   = 1'b1;
        exp_q.push_back(semi_model(CLK_CLAMP, 60000));
        arranque(1, n, nb);
        h = exp_q.pop_front();
        check("clamp_busy", nb, 32);
        check("clamp_arranque", n, int'(LAT) + h);
        medir_ciclo(1, "clamp", h);

        // Two changes while the first division runs; last value must win.
        ifc.en = 1'b0;
        @(negedge clk);
        check("en0_tono_b", ifc.tono_out, 0);
        nb = 0;
        ifc.nota = 16'd440;
        repeat (3) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) nb++;
        end
        ifc.nota = 16'd261;
        repeat (5) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) nb++;
        end
        ifc.nota = 16'd349;
        exp_q.push_back(semi_model(CLK_TB, 349));
        repeat (92) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) nb++;
        end
        check("cambio_doble_busy", nb, 64);
        ifc.en = 1'b1;
        arranque(0, n, nb);
        h = exp_q.pop_front();
        check("t349_arranque", n, h);
        medir_ciclo(0, "t349", h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
